// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32I instruction-fetch sequencer.
// Drives the PC register enable/select and keeps a single outstanding
// request/response transaction to instruction memory. Fetched words go to
// IF/ID with their PC. One word is buffered while IF/ID stalls. A response
// that a redirect has made stale is discarded.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   stall_i                       IF/ID cannot accept this cycle
//   redirect_i, redirect_pc_i     taken branch/jump and its target
//   pc_i                          current PC from the PC register
//   pc_en_o, pc_sel_o             PC write enable; select 0 = pc+4, 1 = pc_target_o
//   pc_target_o                   redirect target passed through
//   imem_req_o, imem_addr_o       fetch request and address
//   imem_ready_i                  grant when imem_req_o && imem_ready_i
//   imem_rvalid_i, imem_rdata_i   instruction response
//   if_valid_o, if_instr_o, if_pc_o  instruction offered to IF/ID
//
// Optional: FETCH_CTRL_PERF_EN adds the saturating counters
//   perf_stall_cnt_o (32) and perf_kill_cnt_o (16).
module fetch_ctrl #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_en_o,
  output logic            pc_sel_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_stall_cnt_o,
  output logic [15:0]     perf_kill_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] buf_instr_q, buf_pc_q;
  logic            buf_ld;
  logic            discard;

  always_comb begin
    state_d     = state_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    buf_ld      = 1'b0;
    discard     = 1'b0;
    pc_en_o     = 1'b0;
    pc_sel_o    = 1'b0;
    pc_target_o = redirect_pc_i;
    imem_req_o  = 1'b0;
    imem_addr_o = pc_i;
    if_valid_o  = 1'b0;
    if_instr_o  = '0;
    if_pc_o     = '0;

    unique case (state_q)
      IDLE: begin
        pc_target_o = '0;
        imem_addr_o = '0;
        state_d     = REQ;
      end
      REQ: begin
        imem_req_o = !redirect_i;
        if (redirect_i) begin
          pc_en_o  = 1'b1;
          pc_sel_o = 1'b1;
        end else if (imem_ready_i) begin
          req_pc_d = pc_i;
          pc_en_o  = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (imem_rvalid_i) begin
          if (kill_q || redirect_i) begin
            discard = 1'b1;
            kill_d  = 1'b0;
            if (redirect_i) begin
              pc_en_o  = 1'b1;
              pc_sel_o = 1'b1;
            end
            state_d = REQ;
          end else if (!stall_i) begin
            if_valid_o = 1'b1;
            if_instr_o = imem_rdata_i;
            if_pc_o    = req_pc_q;
            state_d    = REQ;
          end else begin
            buf_ld  = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect_i) begin
          // Response still in flight: retarget the PC now, drop the word later.
          pc_en_o  = 1'b1;
          pc_sel_o = 1'b1;
          kill_d   = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          pc_en_o  = 1'b1;
          pc_sel_o = 1'b1;
          state_d  = REQ;
        end else begin
          if_valid_o = 1'b1;
          if_instr_o = buf_instr_q;
          if_pc_o    = buf_pc_q;
          if (!stall_i) state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset overrides everything combinationally so outputs are 0 on the
    // very cycle rst_i is high, not only from the following cycle.
    if (rst_i) begin
      state_d     = IDLE;
      kill_d      = 1'b0;
      buf_ld      = 1'b0;
      discard     = 1'b0;
      pc_en_o     = 1'b0;
      pc_sel_o    = 1'b0;
      pc_target_o = '0;
      imem_req_o  = 1'b0;
      imem_addr_o = '0;
      if_valid_o  = 1'b0;
      if_instr_o  = '0;
      if_pc_o     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      kill_q      <= 1'b0;
      req_pc_q    <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      req_pc_q <= req_pc_d;
      if (buf_ld) begin
        buf_instr_q <= imem_rdata_i;
        buf_pc_q    <= req_pc_q;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_cnt_o <= '0;
      perf_kill_cnt_o  <= '0;
    end else begin
      if (if_valid_o && stall_i && !redirect_i && (perf_stall_cnt_o != '1))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      if (discard && (perf_kill_cnt_o != '1))
        perf_kill_cnt_o <= perf_kill_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
// Models the external PC register and a single-outstanding instruction
// memory with programmable response latency. Expected deliveries (PCs) are
// queued as each scenario is driven and compared when IF/ID takes a word.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        pc_en, pc_sel;
  logic [31:0] pc_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [15:0] perf_kill_cnt;
`endif

  fetch_ctrl #(.XLEN(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .pc_i          (pc),
    .pc_en_o       (pc_en),
    .pc_sel_o      (pc_sel),
    .pc_target_o   (pc_target),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ready_i  (imem_ready),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .if_valid_o    (if_valid),
    .if_instr_o    (if_instr),
    .if_pc_o       (if_pc)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt),
    .perf_kill_cnt_o  (perf_kill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a == 32'h4) ? 32'h0050_0093 : (a ^ 32'hA5A5_0013);
  endfunction

  // PC register model
  always @(posedge clk) begin
    if (rst) pc <= '0;
    else if (pc_en) pc <= pc_sel ? pc_target : pc + 32'd4;
  end

  // Instruction memory model: response resp_lat cycles after grant.
  int unsigned resp_lat;
  int unsigned lat_cnt;
  logic [31:0] mem_addr;
  always @(posedge clk) begin
    if (rst) begin
      lat_cnt  <= 0;
      mem_addr <= '0;
    end else if (imem_req && imem_ready) begin
      lat_cnt  <= resp_lat;
      mem_addr <= imem_addr;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
    end
  end
  assign imem_rvalid = (lat_cnt == 1);
  assign imem_rdata  = imem_rvalid ? instr_of(mem_addr) : 32'h0;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    else n_pass++;
  endtask

  // Called once per cycle, after inputs settle, away from the clock edge.
  task automatic observe();
    logic [31:0] e;
    if (if_valid && !stall) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", {31'b0, if_valid}, 32'h0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", if_pc, e);
        chk("sb_instr", if_instr, instr_of(e));
      end
    end
  endtask

  task automatic sample();
    #1;
    observe();
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hDEAD_BEEF;
    stall       = 1'b0;
    imem_ready  = 1'b1;
    resp_lat    = 1;
    repeat (2) begin
      #1;
      chk("rst_ctl", {28'b0, pc_en, pc_sel, imem_req, if_valid}, 32'h0);
      chk("rst_tgt", pc_target, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_ifpc", if_pc | if_instr, 32'h0);
      adv();
    end
    rst      = 1'b0;
    redirect = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_ready = 1'b1; resp_lat = 1;
    @(negedge clk);

    // Back-to-back fetch, 1-cycle memory
    do_reset();
    sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
    for (int k = 0; k < 7; k++) begin
      sample();
      chk("A_valid", {31'b0, if_valid}, (k >= 2 && k % 2 == 0) ? 32'h1 : 32'h0);
      chk("A_pc_en", {31'b0, pc_en}, (k % 2 == 1) ? 32'h1 : 32'h0);
      adv();
    end
    chk("A_sb_empty", sb_q.size(), 32'h0);

    // Stall for 3 cycles when the word at 0x4 returns
    do_reset();
    sb_q.push_back(32'h0); sb_q.push_back(32'h4);
    repeat (4) step();
    stall = 1'b1;
    sample(); chk("B_resp_stall_valid", {31'b0, if_valid}, 32'h0); adv();
    repeat (2) begin
      sample();
      chk("B_hold_valid", {31'b0, if_valid}, 32'h1);
      chk("B_hold_instr", if_instr, 32'h0050_0093);
      chk("B_hold_pc", if_pc, 32'h4);
      chk("B_hold_req", {31'b0, imem_req}, 32'h0);
      chk("B_hold_pc_en", {31'b0, pc_en}, 32'h0);
      adv();
    end
    stall = 1'b0;
    sample();
    chk("B_release_valid", {31'b0, if_valid}, 32'h1);
    chk("B_release_req", {31'b0, imem_req}, 32'h0);
    adv();
    sample();
    chk("B_next_req", {31'b0, imem_req}, 32'h1);
    chk("B_next_addr", imem_addr, 32'h8);
    adv();
    chk("B_sb_empty", sb_q.size(), 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    chk("B_perf_stall", perf_stall_cnt, 32'd2);
`endif

    // Redirect in RESP for 0x8 (response arrives the same cycle)
    do_reset();
    sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h100);
    repeat (6) step();
    redirect = 1'b1; redirect_pc = 32'h100;
    sample();
    chk("C_pc_en", {31'b0, pc_en}, 32'h1);
    chk("C_pc_sel", {31'b0, pc_sel}, 32'h1);
    chk("C_target", pc_target, 32'h100);
    chk("C_valid", {31'b0, if_valid}, 32'h0);
    adv();
    redirect = 1'b0;
    sample();
    chk("C_req", {31'b0, imem_req}, 32'h1);
    chk("C_addr", imem_addr, 32'h100);
    adv();
    step();
    chk("C_sb_empty", sb_q.size(), 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    chk("C_perf_kill", {16'b0, perf_kill_cnt}, 32'd1);
`endif

    // Redirect before the response arrives: kill path, 3-cycle memory
    do_reset();
    resp_lat = 3;
    sb_q.push_back(32'h200);
    step(); step();
    redirect = 1'b1; redirect_pc = 32'h200;
    sample();
    chk("K_pc_en", {31'b0, pc_en}, 32'h1);
    chk("K_pc_sel", {31'b0, pc_sel}, 32'h1);
    chk("K_req", {31'b0, imem_req}, 32'h0);
    adv();
    redirect = 1'b0;
    sample();
    chk("K_wait_req", {31'b0, imem_req}, 32'h0);
    chk("K_wait_valid", {31'b0, if_valid}, 32'h0);
    adv();
    sample();
    chk("K_stale_valid", {31'b0, if_valid}, 32'h0);
    chk("K_stale_pc_en", {31'b0, pc_en}, 32'h0);
    adv();
    sample();
    chk("K_new_req", {31'b0, imem_req}, 32'h1);
    chk("K_new_addr", imem_addr, 32'h200);
    adv();
    repeat (3) step();
    chk("K_sb_empty", sb_q.size(), 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    chk("K_perf_kill", {16'b0, perf_kill_cnt}, 32'd1);
`endif

    // Redirect and stall together while holding
    do_reset();
    sb_q.push_back(32'h40);
    step(); step();
    stall = 1'b1;
    step();
    sample();
    chk("D_hold_valid", {31'b0, if_valid}, 32'h1);
    chk("D_hold_pc", if_pc, 32'h0);
    adv();
    redirect = 1'b1; redirect_pc = 32'h40;
    sample();
    chk("D_valid", {31'b0, if_valid}, 32'h0);
    chk("D_pc_en", {31'b0, pc_en}, 32'h1);
    chk("D_pc_sel", {31'b0, pc_sel}, 32'h1);
    adv();
    redirect = 1'b0; stall = 1'b0;
    sample();
    chk("D_req", {31'b0, imem_req}, 32'h1);
    chk("D_addr", imem_addr, 32'h40);
    adv();
    step();
    chk("D_sb_empty", sb_q.size(), 32'h0);

    // Memory not ready for 5 cycles
    do_reset();
    imem_ready = 1'b0;
    sb_q.push_back(32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("E_req", {31'b0, imem_req}, 32'h1);
      chk("E_addr", imem_addr, 32'h0);
      chk("E_pc_en", {31'b0, pc_en}, 32'h0);
      adv();
    end
    imem_ready = 1'b1;
    sample(); chk("E_grant_pc_en", {31'b0, pc_en}, 32'h1); adv();
    step();
    chk("E_sb_empty", sb_q.size(), 32'h0);

    // Reset while a response is pending
    do_reset();
    step(); step();
    rst = 1'b1;
    sample();
    chk("F_rst_valid", {31'b0, if_valid}, 32'h0);
    chk("F_rst_req", {31'b0, imem_req}, 32'h0);
    adv();
    rst = 1'b0;
    sample(); chk("F_idle_req", {31'b0, imem_req}, 32'h0); adv();
    sb_q.push_back(32'h0);
    sample();
    chk("F_req", {31'b0, imem_req}, 32'h1);
    chk("F_addr", imem_addr, 32'h0);
    adv();
    step();
    chk("F_sb_empty", sb_q.size(), 32'h0);
`ifdef FETCH_CTRL_PERF_EN
    chk("F_perf_kill", {16'b0, perf_kill_cnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the RV32I pipeline. It sits between the hazard and branch-resolution logic and the PC register block, drives the PC register's enable and mux select, and runs a single-outstanding request/response handshake to instruction memory. It delivers each fetched instruction with its PC to the IF/ID stage. It holds one instruction while the pipeline is stalled and discards in-flight fetches that a taken branch or jump has made stale.

## Interface
- XLEN, 32, address and data width
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  IF/ID cannot accept an instruction this cycle
- redirect_i  in  1  taken branch or jump resolved in EX
- redirect_pc_i  in  XLEN  redirect target
- pc_i  in  XLEN  current PC from the PC register
- pc_en_o  out  1  PC register write enable
- pc_sel_o  out  1  0 = pc+4, 1 = pc_target_o
- pc_target_o  out  XLEN  equals redirect_pc_i (combinational)
- imem_req_o  out  1  fetch request
- imem_addr_o  out  XLEN  fetch address, equal to pc_i
- imem_ready_i  in  1  memory accepts the request (grant when req && ready)
- imem_rvalid_i  in  1  response valid, at least 1 cycle after grant
- imem_rdata_i  in  XLEN  instruction word
- if_valid_o  out  1  instruction offered to IF/ID
- if_instr_o  out  XLEN  instruction
- if_pc_o  out  XLEN  PC of the instruction

## Operation
- FSM states: IDLE, REQ, RESP, HOLD.
- Registers: state, req_pc (PC of the granted fetch), kill (in-flight response is stale), buf_instr, buf_pc.
- IDLE (reset state)
  - All outputs 0.
  - Moves to REQ on the next cycle.
- REQ
  - imem_req_o = !redirect_i; imem_addr_o = pc_i.
  - redirect_i: pc_en=1, sel=1; stay in REQ; no grant this cycle.
  - Else on grant: req_pc<=pc_i, pc_en=1, sel=0; go to RESP.
  - stall_i does not block issue.
- RESP
  - imem_req_o = 0.
  - redirect_i without rvalid: pc_en=1, sel=1, kill<=1; stay in RESP.
  - rvalid with (kill or redirect_i): discard the response, kill<=0. If redirect_i, also pc_en=1, sel=1. Go to REQ.
  - rvalid, no kill, no redirect, stall_i=0: if_valid_o=1, if_instr_o=imem_rdata_i, if_pc_o=req_pc (consumed this cycle); go to REQ.
  - rvalid, no kill, no redirect, stall_i=1: buf<=rdata/req_pc, if_valid_o=0; go to HOLD.
- HOLD
  - if_valid_o=1 from buf.
  - redirect_i: drop buf, pc_en=1, sel=1; go to REQ.
  - Else stall_i=0: instruction consumed; go to REQ.
  - Else stay in HOLD.
- Priority: redirect_i over stall_i everywhere.
- pc_en_o is 0 in all cases not listed.
- Only one fetch is outstanding at any time.

## Timing
- Reset: on any cycle with rst_i=1, next state is IDLE, kill=0, all outputs 0. A reset mid-fetch abandons the request; imem shares rst_i and must drop its response.
- Fetch latency: grant at cycle N, PC advanced at edge N+1, earliest if_valid_o at N+1.
- Back-to-back throughput with 1-cycle memory: one instruction per 2 cycles.
- Redirect at cycle N: PC equals target after edge N+1; the request to the target is issued at N+1.
- An instruction offered while redirect_i=1 is never valid (if_valid_o forced 0).
- rvalid in REQ or HOLD is a protocol error and is ignored.

## Configuration
- FETCH_CTRL_PERF_EN defined: adds output perf_stall_cnt_o (32) and output perf_kill_cnt_o (16).
  - perf_stall_cnt_o counts cycles with if_valid_o && stall_i && !redirect_i.
  - perf_kill_cnt_o counts discarded responses.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Test plan
- Reset then 1-cycle memory, no stalls: PC 0x0, 0x4, 0x8 delivered with if_pc_o matching; if_valid_o every 2nd cycle; all outputs 0 while rst_i=1.
- Stall 3 cycles when instr 0x00500093 at 0x4 returns: HOLD keeps if_valid_o=1 with the same data; released on the cycle stall_i falls; no further request during HOLD.
- Redirect to 0x100 while in RESP for 0x8: pc_en=1, sel=1 that cycle; 0x8 response discarded; next fetch address 0x100; perf_kill_cnt_o=1 with macro defined.
- Redirect and stall together in HOLD: buffer dropped, if_valid_o=0, PC to target, state REQ.
- imem_ready_i held low 5 cycles: imem_req_o stays 1 with a stable address; pc_en_o=0 until grant.
- rst_i asserted in RESP: IDLE next cycle, kill cleared, fetch resumes at PC 0x0.
